// File: rtl/alu_serial.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial
//  Description : Bit-serial (slice-serial) ALU. Captures two operands and an
//                opcode, processes SLICE bits per clock LSB-first through a
//                per-bit A_invert/B_invert/carry datapath, and presents the
//                result plus zero/cout/overflow flags under a valid/ready
//                handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_serial #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    // Number of slices per operation; WIDTH must be a multiple of SLICE.
    localparam int N_SLICES = WIDTH / SLICE;
    localparam int CNT_W    = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(N_SLICES - 1);

    // Opcode encoding: bit3 = A_invert, bit2 = B_invert, bits[1:0] = function
    // (00 AND, 01 OR, 10 ADD, 11 SLT).
    localparam logic [3:0] C_OP_AND = 4'b0000;
    localparam logic [3:0] C_OP_OR  = 4'b0001;
    localparam logic [3:0] C_OP_ADD = 4'b0010;
    localparam logic [3:0] C_OP_SUB = 4'b0110;
    localparam logic [3:0] C_OP_NOR = 4'b1100;
    localparam logic [3:0] C_OP_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic [3:0]         op_q,     op_d;
    logic               carry_q,  carry_d;
    logic [WIDTH-1:0]   acc_q,    acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q,   zero_d;
    logic               cout_q,   cout_d;
    logic               ovf_q,    ovf_d;

    logic [SLICE-1:0]   w_a_slice;
    logic [SLICE-1:0]   w_b_slice;
    logic [SLICE-1:0]   w_and_slice;
    logic [SLICE-1:0]   w_or_slice;
    logic [SLICE-1:0]   w_sum_slice;
    logic [SLICE-1:0]   w_slice_res;
    logic               w_carry_msb_in;
    logic               w_slice_cout;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_op_valid;
    logic               w_is_last;

    assign w_is_last  = (cnt_q == C_LAST_CNT);
    assign w_op_valid = (op_q == C_OP_AND) || (op_q == C_OP_OR)  ||
                        (op_q == C_OP_ADD) || (op_q == C_OP_SUB) ||
                        (op_q == C_OP_NOR) || (op_q == C_OP_SLT);

    // Slice datapath: select current slice, run the per-bit invert/carry chain.
    always_comb begin
        logic ai;
        logic bi;
        logic c;
        w_a_slice      = '0;
        w_b_slice      = '0;
        w_and_slice    = '0;
        w_or_slice     = '0;
        w_sum_slice    = '0;
        w_carry_msb_in = 1'b0;
        ai             = 1'b0;
        bi             = 1'b0;
        // Constant-index selection keeps every part-select statically sized.
        for (int s = 0; s < N_SLICES; s++) begin
            if (cnt_q == CNT_W'(s)) begin
                w_a_slice = a_q[s*SLICE +: SLICE];
                w_b_slice = b_q[s*SLICE +: SLICE];
            end
        end
        c = carry_q;
        for (int i = 0; i < SLICE; i++) begin
            ai             = w_a_slice[i] ^ op_q[3];
            bi             = w_b_slice[i] ^ op_q[2];
            w_and_slice[i] = ai & bi;
            w_or_slice[i]  = ai | bi;
            w_sum_slice[i] = ai ^ bi ^ c;
            // Only meaningful on the last slice, where bit SLICE-1 is the MSB.
            if (i == SLICE - 1) begin
                w_carry_msb_in = c;
            end
            c = (ai & bi) | (c & (ai ^ bi));
        end
        w_slice_cout = c;
    end

    // Per-slice function select and write of the slice into the accumulator.
    always_comb begin
        case (op_q[1:0])
            2'b00:   w_slice_res = w_and_slice;
            2'b01:   w_slice_res = w_or_slice;
            default: w_slice_res = w_sum_slice;
        endcase
        w_acc_next = acc_q;
        for (int s = 0; s < N_SLICES; s++) begin
            if (cnt_q == CNT_W'(s)) begin
                w_acc_next[s*SLICE +: SLICE] = w_slice_res;
            end
        end
    end

    // Next-state logic: handshake FSM, slice sequencing and final flag formation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = src1;
                    b_d     = src2;
                    op_d    = ALU_control;
                    // Subtract-style ops feed the +1 of two's complement here.
                    carry_d = ALU_control[2];
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                carry_d = w_slice_cout;
                acc_d   = w_acc_next;
                cnt_d   = cnt_q + 1'b1;
                if (w_is_last) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (!w_op_valid) begin
                        result_d = '0;
                        cout_d   = 1'b0;
                        ovf_d    = 1'b0;
                    end else if (op_q == C_OP_SLT) begin
                        // Signed less-than: sign of A-B corrected by its overflow.
                        result_d    = '0;
                        result_d[0] = w_sum_slice[SLICE-1] ^
                                      (w_carry_msb_in ^ w_slice_cout);
                        cout_d      = w_slice_cout;
                        ovf_d       = 1'b0;
                    end else if (op_q[1]) begin
                        result_d = w_acc_next;
                        cout_d   = w_slice_cout;
                        ovf_d    = w_carry_msb_in ^ w_slice_cout;
                    end else begin
                        result_d = w_acc_next;
                        cout_d   = 1'b0;
                        ovf_d    = 1'b0;
                    end
                    zero_d = (result_d == '0);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over all handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_serial
//  Description : Self-checking bench for alu_serial: table of directed
//                vectors on the default 32/4 instance plus hand-written
//                sequences (backpressure, mid-run reset, single-slice instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] src1, src2, result;
    logic [3:0]  alu_ctl;
    logic        zero, cout, overflow;

    // Single-slice instance (WIDTH=8, SLICE=8)
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [7:0]  s_src1, s_src2, s_result;
    logic [3:0]  s_alu_ctl;
    logic        s_zero, s_cout, s_overflow;

    alu_serial dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .ALU_control(alu_ctl),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .cout(cout), .overflow(overflow)
    );

    alu_serial #(.WIDTH(8), .SLICE(8)) dut_small (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .src1(s_src1), .src2(s_src2), .ALU_control(s_alu_ctl),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .result(s_result), .zero(s_zero), .cout(s_cout), .overflow(s_overflow)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one op on the 32-bit instance; returns edges from accept to out_valid.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, output int lat);
        @(negedge clk);
        src1 = a; src2 = b; alu_ctl = op; in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        in_valid = 1'b0;
        // Scramble inputs after accept: captured values must be used.
        src1 = $urandom; src2 = $urandom; alu_ctl = 4'($urandom);
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        string nm;

        vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 4'b0010, 32'h80000000, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{32'h00000005, 32'h00000005, 4'b0110, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{32'hFFFFFFFF, 32'h00000001, 4'b0111, 32'h00000001, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{32'h0F0F0F0F, 32'h00FF00FF, 4'b1100, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h0F0F0F0F, 32'h00FF00FF, 4'b0001, 32'h0FFF0FFF, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h0F0F0F0F, 32'h00FF00FF, 4'b0000, 32'h000F000F, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 32'h00000001, 4'b0010, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{32'h80000000, 32'h00000001, 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{32'h00000001, 32'hFFFFFFFF, 4'b0111, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{32'h80000000, 32'h00000001, 4'b0111, 32'h00000001, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{32'h12345678, 32'h9ABCDEF0, 4'b1111, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{32'h00000003, 32'h00000005, 4'b0110, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{32'h12345678, 32'h11111111, 4'b0010, 32'h23456789, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{32'h00000005, 32'h00000005, 4'b0111, 32'h00000000, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; src1 = '0; src2 = '0; alu_ctl = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b0; s_src1 = '0; s_src2 = '0; s_alu_ctl = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result",    result,    0);
        chk("rst_zero",      zero,      0);
        chk("rst_cout",      cout,      0);
        chk("rst_overflow",  overflow,  0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors on the default instance
        for (int i = 0; i < NV; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].op, lat);
            nm = $sformatf("v%0d", i);
            chk({nm, "_latency"},  lat,      9);
            chk({nm, "_result"},   result,   vecs[i].res);
            chk({nm, "_zero"},     zero,     vecs[i].z);
            chk({nm, "_cout"},     cout,     vecs[i].c);
            chk({nm, "_overflow"}, overflow, vecs[i].v);
            release_result();
            chk({nm, "_back_idle"}, in_ready, 1);
        end

        // Backpressure in DONE with stray in_valid pulses
        do_op(32'h00000100, 32'h00000023, 4'b0010, lat);
        chk("hold_latency", lat, 9);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = (k % 2 == 0);
            src1 = $urandom; src2 = $urandom; alu_ctl = 4'b0010;
            @(posedge clk);
            #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_result",    result,    32'h00000123);
            chk("hold_in_ready",  in_ready,  0);
        end
        // in_valid is also high on the release edge: it must not be taken.
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("hold_release_idle",  in_ready,  1);
        chk("hold_release_valid", out_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_no_queue", in_ready, 1);

        // Reset in RUN at counter=3 aborts with no out_valid
        @(negedge clk);
        src1 = 32'h55; src2 = 32'h66; alu_ctl = 4'b0010; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_run_valid", out_valid, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_in_ready",  in_ready,  1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result",    result,    0);
        chk("abort_zero",      zero,      0);
        chk("abort_cout",      cout,      0);
        chk("abort_overflow",  overflow,  0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("abort_no_pulse", out_valid, 0);
        do_op(32'd2, 32'd3, 4'b0010, lat);
        chk("post_abort_latency", lat,    9);
        chk("post_abort_result",  result, 32'd5);
        release_result();

        // Single-slice instance: ADD 0xFF + 0x01
        @(negedge clk);
        s_src1 = 8'hFF; s_src2 = 8'h01; s_alu_ctl = 4'b0010; s_in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        s_in_valid = 1'b0; s_src1 = 8'h12; s_src2 = 8'h34; s_alu_ctl = 4'b0001;
        while (!s_out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk("n1_latency",  lat,        2);
        chk("n1_result",   s_result,   8'h00);
        chk("n1_cout",     s_cout,     1);
        chk("n1_zero",     s_zero,     1);
        chk("n1_overflow", s_overflow, 0);
        @(negedge clk);
        s_out_ready = 1'b1;
        @(posedge clk);
        #1;
        s_out_ready = 1'b0;
        chk("n1_back_idle", s_in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_serial.md
ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter SLICE, default 4, bits processed per cycle; WIDTH SHALL be an integer multiple of SLICE, with N = WIDTH/SLICE.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 src1  input  WIDTH  operand A.
REQ-008 src2  input  WIDTH  operand B.
REQ-009 ALU_control  input  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 0111 SLT.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 zero  output  1  result equals 0.
REQ-014 cout  output  1  carry out of MSB.
REQ-015 overflow  output  1  two's-complement overflow.

Function
REQ-016 SHALL use FSM states IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1, out_valid=0; in_valid=1 at an edge SHALL capture src1, src2, ALU_control and go to RUN, with slice counter=0.
REQ-018 RUN: in_ready=0; each cycle SHALL process slice [counter*SLICE +: SLICE] using per-bit A_invert/B_invert/carry logic, register the slice carry, and increment the counter.
REQ-019 Counter SHALL run 0..N-1; after the edge processing slice N-1, state SHALL go to DONE with result/flags registered.
REQ-020 Latency SHALL be exactly N+1 edges from the accept edge to out_valid=1 (N=8 at defaults -> 9).
REQ-021 DONE: out_valid=1, outputs stable while out_ready=0; out_valid&out_ready at an edge SHALL return to IDLE.
REQ-022 in_ready SHALL be high only in IDLE; no same-cycle bypass from DONE to accept.
REQ-023 Captured operands SHALL be used; src1/src2/ALU_control changes after accept SHALL have no effect.
REQ-024 SUB and SLT SHALL use B_invert=1, initial carry=1; ADD initial carry=0; NOR SHALL use A_invert=B_invert=1 with AND.
REQ-025 SLT result SHALL be {WIDTH-1 zeros, sign(A-B) XOR overflow(A-B)}, a signed comparison.
REQ-026 cout SHALL equal the MSB carry for ADD/SUB/SLT, 0 for AND/OR/NOR.
REQ-027 overflow SHALL equal carry-into-MSB XOR carry-out-of-MSB for ADD/SUB, 0 for all other opcodes.
REQ-028 zero SHALL be 1 iff the final result is all zeros, for every opcode.
REQ-029 Undefined opcodes SHALL complete with identical latency and produce result=0, zero=1, cout=0, overflow=0.
REQ-030 Arithmetic SHALL wrap modulo 2^WIDTH.
REQ-031 in_valid while not in IDLE SHALL be ignored and not queued.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE, counter=0, out_valid=0, result=0, zero=0, cout=0, overflow=0, and in_ready=1 the following cycle.
REQ-033 rst during RUN or DONE SHALL abort the operation with no out_valid pulse; rst SHALL take priority over every handshake.

Verification
REQ-034 Defaults, ADD 0x7FFFFFFF + 0x00000001 -> after 9 edges result=0x80000000, overflow=1, cout=0, zero=0.
REQ-035 SUB 0x00000005 - 0x00000005 -> result=0, zero=1, cout=1, overflow=0; SLT 0xFFFFFFFF vs 0x00000001 -> result=1.
REQ-036 NOR 0x0F0F0F0F, 0x00FF00FF -> result=0xF000F000; OR of the same operands -> 0x0FFF0FFF, cout=0.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> out_valid and result stable, in_ready=0; in_valid pulses are ignored; out_ready=1 -> IDLE next edge.
REQ-038 Assert rst at RUN counter=3 -> out_valid never asserted, all outputs 0, in_ready=1 next cycle; a new ADD 2+3 then yields 5.
REQ-039 WIDTH=8, SLICE=8 (N=1): ADD 0xFF+0x01 -> latency 2 edges, result=0x00, cout=1, zero=1, overflow=0.
